// File: rtl/tcdm_bank_responder.sv
// ============================================================================
// tcdm_bank_responder : TCDM bank-side responder (loads, stores, AMO RMW)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tcdm_bank_responder #(
  parameter int unsigned RespFifoDepth = 2,
  parameter int unsigned AddrMemWidth  = 10,
  parameter int unsigned BankSelWidth  = 4,
  parameter int unsigned META_ID_W     = 4,
  parameter int unsigned CORE_ID_W     = 3,
  parameter int unsigned INI_ADDR_W    = 4,
  localparam int unsigned c_TGT_W  = AddrMemWidth + BankSelWidth,
  localparam int unsigned c_PL_W   = META_ID_W + CORE_ID_W + 4 + 1 + 32,
  localparam int unsigned c_REQ_W  = c_PL_W + 1 + 4 + c_TGT_W + INI_ADDR_W,
  localparam int unsigned c_RESP_W = c_PL_W + INI_ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [c_REQ_W-1:0]      req_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [c_RESP_W-1:0]     resp_o,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [AddrMemWidth-1:0] sram_addr_o,
  output logic [31:0]             sram_wdata_o,
  output logic [3:0]              sram_be_o,
  input  logic [31:0]             sram_rdata_i
);

  // Payload layout (MSB..LSB): meta_id, core_id, amo, lrwait, data.
  // Request layout: payload, wen, be, tgt_addr, ini_addr.  Response: payload, ini_addr.
  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_AMO_WR = 1'b1;
  localparam int unsigned c_PTR_W = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
  localparam int unsigned c_CNT_W = $clog2(RespFifoDepth + 1);

  logic [INI_ADDR_W-1:0]   w_req_ini;
  logic [c_TGT_W-1:0]      w_req_tgt;
  logic [3:0]              w_req_be;
  logic                    w_req_wen;
  logic [c_PL_W-1:0]       w_req_pl;
  logic [3:0]              w_req_amo;
  logic [AddrMemWidth-1:0] w_req_addr;
  logic                    w_is_amo;
  logic                    w_is_store;
  logic                    w_credit_ok;
  logic                    w_accept;
  logic                    w_accept_rd;
  logic [c_CNT_W:0]        w_outstanding;

  assign w_req_ini  = req_i[INI_ADDR_W-1:0];
  assign w_req_tgt  = req_i[INI_ADDR_W +: c_TGT_W];
  assign w_req_be   = req_i[INI_ADDR_W + c_TGT_W +: 4];
  assign w_req_wen  = req_i[INI_ADDR_W + c_TGT_W + 4];
  assign w_req_pl   = req_i[c_REQ_W-1 -: c_PL_W];
  assign w_req_amo  = w_req_pl[36:33];
  assign w_req_addr = w_req_tgt[BankSelWidth +: AddrMemWidth];

  // Opcodes 10..15 fall out of both classes and are served as plain loads.
  assign w_is_amo   = (w_req_amo != 4'd0) && (w_req_amo <= 4'd9);
  assign w_is_store = w_req_wen && (w_req_amo == 4'd0);

  logic [0:0]              r_state;
  logic                    r_inflight;
  logic                    r_is_amo;
  logic [c_PL_W-1:0]       r_pl;
  logic [INI_ADDR_W-1:0]   r_ini;
  logic [AddrMemWidth-1:0] r_addr;

  logic [c_RESP_W-1:0]     r_mem [RespFifoDepth];
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_CNT_W-1:0]      r_count;

  // Credit counts the response still inside the SRAM pipeline, ignoring any same-cycle pop.
  assign w_outstanding = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
  assign w_credit_ok   = w_outstanding < (c_CNT_W+1)'(RespFifoDepth);

  assign req_ready_o = rst_ni && (r_state == c_IDLE) && (w_credit_ok || w_is_store);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_accept_rd = w_accept && !w_is_store;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= c_IDLE;
      r_inflight <= 1'b0;
      r_is_amo   <= 1'b0;
      r_pl       <= '0;
      r_ini      <= '0;
      r_addr     <= '0;
    end else begin
      r_inflight <= w_accept_rd;
      if (w_accept_rd) begin
        r_is_amo <= w_is_amo;
        r_pl     <= w_req_pl;
        r_ini    <= w_req_ini;
        r_addr   <= w_req_addr;
      end
      if ((r_state == c_IDLE) && w_accept_rd && w_is_amo) begin
        r_state <= c_AMO_WR;
      end else begin
        r_state <= c_IDLE;
      end
    end
  end

  logic [31:0] w_old;
  logic [31:0] w_op;
  logic [31:0] w_amo_res;

  assign w_old = sram_rdata_i;
  assign w_op  = r_pl[31:0];

  always_comb begin
    w_amo_res = w_old;
    case (r_pl[36:33])
      4'd1: w_amo_res = w_op;
      4'd2: w_amo_res = w_old + w_op;
      4'd3: w_amo_res = w_old & w_op;
      4'd4: w_amo_res = w_old | w_op;
      4'd5: w_amo_res = w_old ^ w_op;
      4'd6: w_amo_res = ($signed(w_old) > $signed(w_op)) ? w_old : w_op;
      4'd7: w_amo_res = (w_old > w_op) ? w_old : w_op;
      4'd8: w_amo_res = ($signed(w_old) < $signed(w_op)) ? w_old : w_op;
      4'd9: w_amo_res = (w_old < w_op) ? w_old : w_op;
      default: w_amo_res = w_old;
    endcase
  end

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = 4'h0;
    if (r_state == c_AMO_WR) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = r_addr;
      sram_wdata_o = w_amo_res;
      sram_be_o    = 4'hF;
    end else if (w_accept) begin
      sram_req_o   = 1'b1;
      sram_we_o    = w_is_store;
      sram_addr_o  = w_req_addr;
      sram_wdata_o = w_is_store ? w_req_pl[31:0] : 32'h0;
      sram_be_o    = w_is_store ? w_req_be : 4'hF;
    end
  end

  logic                w_fifo_empty;
  logic                w_pop;
  logic                w_pop_mem;
  logic                w_push;
  logic [c_RESP_W-1:0] w_push_resp;

  assign w_fifo_empty = (r_count == '0);
  assign w_push_resp  = {r_pl[c_PL_W-1:32], sram_rdata_i, r_ini};

  // Fall-through: with an empty FIFO the SRAM read data drives resp_o directly.
  assign resp_valid_o = r_inflight || !w_fifo_empty;
  assign resp_o       = w_fifo_empty ? w_push_resp : r_mem[r_rd_ptr];
  assign w_pop        = resp_valid_o && resp_ready_i;
  assign w_pop_mem    = w_pop && !w_fifo_empty;
  assign w_push       = r_inflight && !(w_fifo_empty && w_pop);

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] ptr);
    f_ptr_inc = (ptr == c_PTR_W'(RespFifoDepth - 1)) ? '0 : ptr + c_PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)    r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop_mem) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop_mem);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_resp;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tcdm_bank_responder.sv
// ============================================================================
// tb_tcdm_bank_responder : vector table + scoreboard bench for the bank responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tcdm_bank_responder;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned AMW    = 10;
  localparam int unsigned BSW    = 4;
  localparam int unsigned METAW  = 4;
  localparam int unsigned COREW  = 3;
  localparam int unsigned INIW   = 4;
  localparam int unsigned TGTW   = AMW + BSW;
  localparam int unsigned PLW    = METAW + COREW + 4 + 1 + 32;
  localparam int unsigned REQW   = PLW + 1 + 4 + TGTW + INIW;
  localparam int unsigned RESPW  = PLW + INIW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [REQW-1:0]  req;
  logic             resp_valid;
  logic             resp_ready;
  logic [RESPW-1:0] resp;
  logic             sram_req;
  logic             sram_we;
  logic [AMW-1:0]   sram_addr;
  logic [31:0]      sram_wdata;
  logic [3:0]       sram_be;
  logic [31:0]      sram_rdata;

  always #5 clk = ~clk;

  tcdm_bank_responder #(
    .RespFifoDepth(DEPTH), .AddrMemWidth(AMW), .BankSelWidth(BSW),
    .META_ID_W(METAW), .CORE_ID_W(COREW), .INI_ADDR_W(INIW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_o(resp),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  // Bank macro: byte-enabled write, one-cycle registered read.
  logic [31:0] mem [1 << AMW];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic        wen;
    logic [3:0]  amo;
    logic [9:0]  word;
    logic [31:0] data;
    logic [3:0]  be;
    logic [3:0]  meta;
    logic [3:0]  ini;
    logic        has_resp;
    logic [31:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [RESPW-1:0] sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic wen, input logic [3:0] amo, input logic [9:0] word,
                              input logic [31:0] data, input logic [3:0] be,
                              input logic [3:0] meta, input logic [3:0] ini,
                              input logic has_resp, input logic [31:0] exp);
    vec_t v;
    v.wen = wen; v.amo = amo; v.word = word; v.data = data; v.be = be;
    v.meta = meta; v.ini = ini; v.has_resp = has_resp; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t st(input logic [9:0] w, input logic [31:0] d, input logic [3:0] be);
    return mk(1'b1, 4'd0, w, d, be, 4'd0, 4'd0, 1'b0, 32'h0);
  endfunction

  function automatic vec_t ld(input logic [9:0] w, input logic [3:0] meta, input logic [3:0] ini,
                              input logic [31:0] exp);
    return mk(1'b0, 4'd0, w, 32'h0, 4'hF, meta, ini, 1'b1, exp);
  endfunction

  function automatic vec_t am(input logic [3:0] op, input logic [9:0] w, input logic [31:0] d,
                              input logic [3:0] meta, input logic [31:0] exp);
    return mk(1'b0, op, w, d, 4'hF, meta, 4'd2, 1'b1, exp);
  endfunction

  function automatic logic [REQW-1:0] enc_req(input vec_t v);
    logic [COREW-1:0] core;
    logic [TGTW-1:0]  tgt;
    core = v.meta[2:0] ^ 3'h5;
    tgt  = {v.word, 4'hA};
    return {v.meta, core, v.amo, v.ini[0], v.data, v.wen, v.be, tgt, v.ini};
  endfunction

  function automatic logic [RESPW-1:0] enc_resp(input vec_t v);
    logic [COREW-1:0] core;
    core = v.meta[2:0] ^ 3'h5;
    return {v.meta, core, v.amo, v.ini[0], v.exp, v.ini};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge, valid left high.
  task automatic issue(input vec_t v, input bit push_exp);
    bit done;
    done = 1'b0;
    req_valid = 1'b1;
    req = enc_req(v);
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        done = 1'b1;
        if (push_exp && v.has_resp) sb.push_back(enc_resp(v));
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout word %0d amo %0d", v.word, v.amo);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout left %0d want 0", sb.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got %h expected none", resp);
      end else begin
        logic [RESPW-1:0] e;
        e = sb.pop_front();
        if (resp !== e) begin
          errors++;
          $display("FAIL resp got %h expected %h", resp, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    resp_ready = 1'b1;
    req_valid = 1'b1;
    req = enc_req(st(10'd1, 32'h12345678, 4'hF));

    // Reset state with a store being offered.
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_sram_req", {31'd0, sram_req}, 32'd0);
    chk("rst_sram_we", {31'd0, sram_we}, 32'd0);
    chk("rst_sram_addr", {22'd0, sram_addr}, 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    chk("rst_sram_be", {28'd0, sram_be}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl.push_back(st(10'd5, 32'hDEADBEEF, 4'hF));
    tbl.push_back(ld(10'd5, 4'd3, 4'd1, 32'hDEADBEEF));
    tbl.push_back(st(10'd9, 32'h80000000, 4'hF));
    tbl.push_back(am(4'd6, 10'd9, 32'h1, 4'd4, 32'h80000000));
    tbl.push_back(ld(10'd9, 4'd5, 4'd3, 32'h00000001));
    tbl.push_back(st(10'd9, 32'h80000000, 4'hF));
    tbl.push_back(am(4'd7, 10'd9, 32'h1, 4'd6, 32'h80000000));
    tbl.push_back(ld(10'd9, 4'd7, 4'd4, 32'h80000000));
    tbl.push_back(st(10'd11, 32'h11223344, 4'hF));
    tbl.push_back(st(10'd11, 32'h0000AB00, 4'b0010));
    tbl.push_back(ld(10'd11, 4'd8, 4'd5, 32'h1122AB44));
    tbl.push_back(st(10'd12, 32'h12345678, 4'hF));
    tbl.push_back(am(4'd1, 10'd12, 32'hCAFEF00D, 4'd9, 32'h12345678));
    tbl.push_back(ld(10'd12, 4'd10, 4'd6, 32'hCAFEF00D));
    tbl.push_back(st(10'd13, 32'hF0F0F0F0, 4'hF));
    tbl.push_back(am(4'd3, 10'd13, 32'hFF00FF00, 4'd11, 32'hF0F0F0F0));
    tbl.push_back(am(4'd4, 10'd13, 32'h0000000F, 4'd12, 32'hF000F000));
    tbl.push_back(am(4'd5, 10'd13, 32'hFFFFFFFF, 4'd13, 32'hF000F00F));
    tbl.push_back(ld(10'd13, 4'd14, 4'd7, 32'h0FFF0FF0));
    tbl.push_back(st(10'd14, 32'h00000005, 4'hF));
    tbl.push_back(am(4'd8, 10'd14, 32'hFFFFFFFE, 4'd15, 32'h00000005));
    tbl.push_back(ld(10'd14, 4'd1, 4'd8, 32'hFFFFFFFE));
    tbl.push_back(am(4'd9, 10'd14, 32'h00000003, 4'd2, 32'hFFFFFFFE));
    tbl.push_back(ld(10'd14, 4'd3, 4'd9, 32'h00000003));
    tbl.push_back(mk(1'b1, 4'd12, 10'd14, 32'h00000999, 4'hF, 4'd4, 4'd10, 1'b1, 32'h00000003));
    tbl.push_back(ld(10'd14, 4'd5, 4'd11, 32'h00000003));
    tbl.push_back(st(10'd15, 32'h00000010, 4'hF));
    tbl.push_back(mk(1'b0, 4'd2, 10'd15, 32'h1, 4'h0, 4'd6, 4'd12, 1'b1, 32'h00000010));
    tbl.push_back(ld(10'd15, 4'd7, 4'd13, 32'h00000011));

    foreach (tbl[i]) issue(tbl[i], 1'b1);
    idle();
    drain();

    // AMO add wrap-around; the following load stalls during the write-back cycle.
    issue(st(10'd7, 32'hFFFFFFFF, 4'hF), 1'b1);
    issue(am(4'd2, 10'd7, 32'h2, 4'd9, 32'hFFFFFFFF), 1'b1);
    req = enc_req(ld(10'd7, 4'd2, 4'd1, 32'h1));
    @(negedge clk);
    chk("amo_wr_ready", {31'd0, req_ready}, 32'd0);
    chk("amo_wr_we", {31'd0, sram_we}, 32'd1);
    chk("amo_wr_addr", {22'd0, sram_addr}, 32'd7);
    chk("amo_wr_wdata", sram_wdata, 32'h00000001);
    @(posedge clk);
    #1;
    issue(ld(10'd7, 4'd2, 4'd1, 32'h00000001), 1'b1);
    idle();
    drain();

    // Back-pressure: credit stops loads at DEPTH, stores still pass.
    issue(st(10'd20, 32'hA0A0A0A0, 4'hF), 1'b1);
    issue(st(10'd21, 32'hA1A1A1A1, 4'hF), 1'b1);
    resp_ready = 1'b0;
    issue(ld(10'd20, 4'd1, 4'd1, 32'hA0A0A0A0), 1'b1);
    issue(ld(10'd21, 4'd2, 4'd2, 32'hA1A1A1A1), 1'b1);
    req = enc_req(ld(10'd22, 4'd3, 4'd3, 32'hA2A2A2A2));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("full_ready", {31'd0, req_ready}, 32'd0);
      chk("full_valid", {31'd0, resp_valid}, 32'd1);
      chk("full_hold", resp[INIW +: 32], 32'hA0A0A0A0);
      @(posedge clk);
      #1;
    end
    req = enc_req(st(10'd22, 32'hA2A2A2A2, 4'hF));
    @(negedge clk);
    chk("full_store_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    issue(ld(10'd22, 4'd3, 4'd3, 32'hA2A2A2A2), 1'b1);
    issue(ld(10'd20, 4'd4, 4'd4, 32'hA0A0A0A0), 1'b1);
    idle();
    drain();

    // Reset during the write-back cycle drops the write and the response.
    issue(st(10'd30, 32'h00000055, 4'hF), 1'b1);
    issue(am(4'd2, 10'd30, 32'h1, 4'd5, 32'h00000055), 1'b0);
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstamo_sram_req", {31'd0, sram_req}, 32'd0);
    chk("rstamo_sram_we", {31'd0, sram_we}, 32'd0);
    chk("rstamo_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstamo_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstamo_mem", mem[30], 32'h00000055);
    issue(ld(10'd30, 4'd6, 4'd6, 32'h00000055), 1'b1);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
